// File: rtl/fechadura_pkg.sv
// Shared definitions for the lock keypad path.
// Key codes coming from the matrix-keypad decoder and the PIN assembler states.
package fechadura_pkg;

   localparam logic [3:0] TECLA_ASTERISCO = 4'hA;
   localparam logic [3:0] TECLA_CERQUILHA = 4'hB;
   localparam logic [3:0] BCD_BLANK       = 4'hF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTRADA = 2'd1,
      PRONTO  = 2'd2
   } estado_t;

endpackage

// File: rtl/montador_senha_if.sv
// PIN handoff between the PIN assembler (master) and the operational FSM (slave).
//   pin_bcd   : packed BCD PIN, newest digit in [3:0], unused nibbles 0xF
//   pin_len   : number of valid digits in pin_bcd
//   pin_valid : PIN ready, held until pin_ack
//   pin_ack   : consumer accepted the PIN
interface montador_senha_if #(
   parameter int MAX_DIGITS = 12
);
   localparam int LEN_W = $clog2(MAX_DIGITS + 1);

   logic [4*MAX_DIGITS-1:0] pin_bcd;
   logic [LEN_W-1:0]        pin_len;
   logic                    pin_valid;
   logic                    pin_ack;

   modport master (output pin_bcd, pin_len, pin_valid, input pin_ack);
   modport slave  (input pin_bcd, pin_len, pin_valid, output pin_ack);
endinterface

// File: rtl/montador_senha_contador.sv
// Inactivity down-counter. Loads TICKS-1 on restart or while not running and
// counts down while run is high; expire pulses for the single cycle in which
// the count sits at zero, after which it reloads.
//   clk, rst : clock, async active-low reset
//   restart  : reload the count (wins over expiry)
//   run      : count enable
//   expire   : one-cycle pulse after TICKS running cycles without restart
module contador_inatividade #(
   parameter int TICKS = 250_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic run,
   output logic expire
);
   localparam int               CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CNT_W-1:0] CARGA = CNT_W'(TICKS - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= CARGA;
      end else if (restart || !run || cnt == '0) begin
         cnt <= CARGA;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = run & ~restart & (cnt == '0);

endmodule

// File: rtl/montador_senha.sv
// PIN assembler: turns one-cycle keypad events into a packed-BCD PIN of
// variable length, hands it to the operational FSM over pin_if, and feeds a
// 6-digit view of the entry to the display.
//   clk, rst       : clock, async active-low reset
//   enable         : entry allowed
//   digitos_value  : key code (0-9 digit, 0xA '*', 0xB '#', 0xC-0xF ignored)
//   digitos_valid  : strobe qualifying digitos_value
//   pin_if         : PIN handoff (master side)
//   disp_bcd       : last 6 digits, newest in [3:0], blanks 0xF
//   bip_tecla      : pulse per accepted key
//   erro           : pulse on submit with too few digits
//   timeout        : pulse when entry is abandoned for inactivity
//
// state   | meaning
// IDLE    | buffer empty, waiting for the first digit
// ENTRADA | digits being typed, inactivity timer running
// PRONTO  | PIN presented on pin_if, frozen until pin_ack
module montador_senha
   import fechadura_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int TIMEOUT_S   = 5,
   parameter int MAX_DIGITS  = 12,
   parameter int MIN_DIGITS  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [3:0]               digitos_value,
   input  logic                     digitos_valid,
   montador_senha_if.master         pin_if,
   output logic [23:0]              disp_bcd,
   output logic                     bip_tecla,
   output logic                     erro,
   output logic                     timeout
);
   localparam int               LEN_W   = $clog2(MAX_DIGITS + 1);
   localparam int               BUF_W   = 4 * MAX_DIGITS;
   localparam int               TICKS   = TIMEOUT_S * CLK_FREQ_HZ;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_DIGITS);
   localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_DIGITS);

   estado_t          state;
   logic [BUF_W-1:0] pin_bcd;
   logic [LEN_W-1:0] pin_len;
   logic             pin_valid;

   logic tecla_ok;
   logic is_digit;
   logic expire;

   assign is_digit = (digitos_value <= 4'd9);
   // Codes 0xC-0xF never count as a key, so they neither bip nor restart the timer.
   assign tecla_ok = digitos_valid & enable & (state != PRONTO) &
                     (digitos_value <= TECLA_CERQUILHA);

   // Every accepted digit restarts the timer, including one dropped on a full buffer.
   contador_inatividade #(.TICKS(TICKS)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .restart (tecla_ok & is_digit),
      .run     (state == ENTRADA),
      .expire  (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pin_bcd   <= {MAX_DIGITS{BCD_BLANK}};
         pin_len   <= '0;
         pin_valid <= 1'b0;
         bip_tecla <= 1'b0;
         erro      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         bip_tecla <= 1'b0;
         erro      <= 1'b0;
         timeout   <= 1'b0;
         case (state)
            PRONTO: begin
               if (pin_if.pin_ack) begin
                  state     <= IDLE;
                  pin_bcd   <= {MAX_DIGITS{BCD_BLANK}};
                  pin_len   <= '0;
                  pin_valid <= 1'b0;
               end
            end
            default: begin
               if (!enable) begin
                  state   <= IDLE;
                  pin_bcd <= {MAX_DIGITS{BCD_BLANK}};
                  pin_len <= '0;
               end else if (tecla_ok) begin
                  if (is_digit) begin
                     state <= ENTRADA;
                     if (pin_len < LEN_MAX) begin
                        pin_bcd   <= {pin_bcd[BUF_W-5:0], digitos_value};
                        pin_len   <= pin_len + LEN_W'(1);
                        bip_tecla <= 1'b1;
                     end
                  end else if (digitos_value == TECLA_ASTERISCO) begin
                     state     <= IDLE;
                     pin_bcd   <= {MAX_DIGITS{BCD_BLANK}};
                     pin_len   <= '0;
                     bip_tecla <= 1'b1;
                  end else if (pin_len >= LEN_MIN) begin
                     state     <= PRONTO;
                     pin_valid <= 1'b1;
                     bip_tecla <= 1'b1;
                  end else begin
                     state   <= IDLE;
                     pin_bcd <= {MAX_DIGITS{BCD_BLANK}};
                     pin_len <= '0;
                     erro    <= 1'b1;
                  end
               end else if (state == ENTRADA && expire) begin
                  state   <= IDLE;
                  pin_bcd <= {MAX_DIGITS{BCD_BLANK}};
                  pin_len <= '0;
                  timeout <= 1'b1;
               end
            end
         endcase
      end
   end

   assign pin_if.pin_bcd   = pin_bcd;
   assign pin_if.pin_len   = pin_len;
   assign pin_if.pin_valid = pin_valid;
   assign disp_bcd         = pin_bcd[23:0];

endmodule

// File: doc/montador_senha.md
Name: montador_senha

Overview:
- Sits between the matrix-keypad decoder and the operational FSM.
- Consumes one-cycle key events (digitos_value/digitos_valid) and assembles them into a packed-BCD PIN of variable length.
- Presents the PIN to the consumer with a valid/ack handshake and drives a 6-digit BCD view of the entry for the display path.
- Handles clear ('*'), submit ('#'), minimum/maximum length and an inactivity timeout.

Parameters:
- CLK_FREQ_HZ, 50_000_000: clock frequency, used to derive the timeout.
- TIMEOUT_S, 5: inactivity timeout in seconds.
- MAX_DIGITS, 12: PIN buffer capacity in digits.
- MIN_DIGITS, 4: minimum length accepted on submit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- enable  in  1  entry allowed (driven by the operational FSM)
- digitos_value  in  4  key code: 0-9 digit, 0xA '*', 0xB '#', 0xC-0xF ignored
- digitos_valid  in  1  one-cycle strobe qualifying digitos_value
- pin_bcd  out  4*MAX_DIGITS  packed PIN; newest digit in [3:0]; unused nibbles 0xF
- pin_len  out  $clog2(MAX_DIGITS+1)  number of digits in pin_bcd
- pin_valid  out  1  PIN ready; held until pin_ack
- pin_ack  in  1  consumer accepted the PIN
- disp_bcd  out  24  last 6 digits, newest in [3:0]; empty positions 0xF (blank)
- bip_tecla  out  1  one-cycle pulse per accepted key
- erro  out  1  one-cycle pulse: submit with too few digits
- timeout  out  1  one-cycle pulse: entry abandoned after inactivity

Behaviour:
- Reset (rst=0, async):
  - state IDLE; pin_bcd all 0xF; pin_len 0; disp_bcd 0xFFFFFF.
  - pin_valid, bip_tecla, erro, timeout all 0; timer cleared.
- Key acceptance: a key counts only when digitos_valid=1, enable=1 and state is not PRONTO. All outputs are registered; effects appear one cycle after the strobe.
- FSM states:
  - IDLE: empty buffer.
    - Digit -> shift in (pin_bcd <= {pin_bcd[..-5:0], d}), pin_len=1, go to ENTRADA, bip_tecla.
    - '*' -> bip_tecla only.
    - '#' -> erro pulse (length 0 < MIN_DIGITS); no bip.
  - ENTRADA:
    - Digit with pin_len<MAX_DIGITS -> shift in, pin_len+1, bip_tecla, timer restart.
    - Digit with pin_len==MAX_DIGITS -> ignored; no bip; timer restart.
    - '*' -> clear buffer, go to IDLE, bip_tecla.
    - '#' with pin_len>=MIN_DIGITS -> go to PRONTO, pin_valid=1, bip_tecla.
    - '#' with pin_len<MIN_DIGITS -> erro pulse, clear buffer, go to IDLE.
    - Codes 0xC-0xF: no effect, timer not restarted.
  - PRONTO:
    - pin_valid=1; pin_bcd and pin_len frozen; all keys ignored.
    - pin_ack=1 -> clear buffer, pin_valid=0 next cycle, go to IDLE.
- Timer:
  - Counts only in ENTRADA; terminal count TIMEOUT_S*CLK_FREQ_HZ-1.
  - At terminal count: timeout pulse, clear buffer, go to IDLE.
  - A key on the same cycle as terminal count takes priority: the key is processed and the timer restarts.
- enable falling: in ENTRADA -> clear, go to IDLE, no pulse. In PRONTO -> hold until ack.
- Priority, highest first: rst, pin_ack, enable low, key, timer expiry.
- disp_bcd: always equals pin_bcd[23:0].

Decomposition:
- Package fechadura_pkg:
  - key code constants: TECLA_ASTERISCO=4'hA, TECLA_CERQUILHA=4'hB, BCD_BLANK=4'hF.
  - state enum {IDLE, ENTRADA, PRONTO}.
- Sub-module contador_inatividade:
  - parameter TICKS; inputs restart and run; output one-cycle expire pulse.
  - Also reusable by the 5 s reset-hold logic.

Test Plan:
- Sim with CLK_FREQ_HZ=100, TIMEOUT_S=1, MIN_DIGITS=4, MAX_DIGITS=12.
- Keys 1,2,3,4,'#' -> 5 bip_tecla pulses; pin_valid=1; pin_len=4; pin_bcd[15:0]=16'h1234, upper nibbles 0xF; pin_ack -> pin_valid=0, pin_len=0, disp_bcd=24'hFFFFFF.
- Keys 7,8,'#' -> erro pulse exactly one cycle after '#'; state IDLE; pin_len=0; no pin_valid.
- 13 keys 0..9,1,2,3 then '#' -> pin_len=12, pin_bcd=48'h012345678912; 13th key gives no bip; disp_bcd=24'h678912.
- Key 5, then idle 100 cycles -> timeout pulse at cycle 100 after the key; pin_len=0. Repeat with a second key at cycle 99 -> no timeout, pin_len=2.
- In PRONTO, press 9 -> pin_bcd unchanged, no bip. Separately, in ENTRADA with 3 digits, drop enable -> buffer cleared; no erro, no timeout.
- Assert rst mid-ENTRADA with 3 digits -> outputs return to reset values immediately (async, before the next clk edge); keys are accepted normally after release.
